melody_player: RTL and testbench

MELODY_PLAYER -- requirements
Module: melody_player

---
 rtl/melody_player_pkg.sv | 35 +++
 rtl/melody_player_unit_timer.sv | 59 +++++
 rtl/melody_player.sv | 202 ++++++++++++++++++++
 tb/tb_melody_player.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_player_pkg.sv
// -----------------------------------------------------------------------------
// melody_player_pkg
//   Shared definitions for the melody player:
//     - state_t           : playback FSM state encoding
//     - DEF_SPEAKER_ADDR  : default peripheral address of the speaker
//     - DEF_BUTTON_ADDR   : default peripheral address of the button register
//     - NOTE_MIN/NOTE_MAX : valid note-code range; NOTE_REST (0) is a rest
//     - is_note_code()    : helper to classify a ROM note byte
// -----------------------------------------------------------------------------
package melody_player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_POLL     = 3'd1,
        ST_FETCH    = 3'd2,
        ST_WAIT_ROM = 3'd3,
        ST_PLAY     = 3'd4,
        ST_HOLD     = 3'd5,
        ST_GAP      = 3'd6,
        ST_SILENCE  = 3'd7
    } state_t;

    localparam int unsigned DEF_SPEAKER_ADDR = 9;
    localparam int unsigned DEF_BUTTON_ADDR  = 0;

    localparam logic [7:0] NOTE_REST = 8'd0;
    localparam logic [7:0] NOTE_MIN  = 8'd60;
    localparam logic [7:0] NOTE_MAX  = 8'd96;

    // True for a rest or for a note code the speaker understands.
    function automatic logic is_note_code(input logic [7:0] note);
        return (note == NOTE_REST) || ((note >= NOTE_MIN) && (note <= NOTE_MAX));
    endfunction

endpackage

// File: rtl/melody_player_unit_timer.sv
// -----------------------------------------------------------------------------
// melody_player_unit_timer
//   Tick prescaler plus 8-bit unit down-counter. A load clears the prescaler
//   and loads the unit count; while i_run is high the prescaler counts
//   TICKS_PER_UNIT cycles per unit. o_expire is high during the final cycle of
//   the loaded interval, so an interval of N units lasts N*TICKS_PER_UNIT
//   cycles counted from the first cycle after the load.
//
// Ports
//   i_clk      : clock
//   i_reset_n  : asynchronous active-low reset
//   i_load     : clear prescaler and load i_units (has priority over i_run)
//   i_units    : number of units to time
//   i_run      : count enable
//   o_expire   : last cycle of the timed interval
// -----------------------------------------------------------------------------
module melody_player_unit_timer #(
    parameter int unsigned TICKS_PER_UNIT = 12000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_load,
    input  logic [7:0] i_units,
    input  logic       i_run,
    output logic       o_expire
);

    localparam int unsigned TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);

    logic [TICK_W-1:0] r_tick;
    logic [7:0]        r_units;
    logic              w_unit_end;

    assign w_unit_end = (r_tick == TICK_LAST);

    // A unit count of 0 behaves like 1 so the timer can never lock up.
    assign o_expire = i_run && w_unit_end && (r_units <= 8'd1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tick  <= '0;
            r_units <= '0;
        end else if (i_load) begin
            r_tick  <= '0;
            r_units <= i_units;
        end else if (i_run) begin
            if (w_unit_end) begin
                r_tick <= '0;
                if (r_units != 8'd0) begin
                    r_units <= r_units - 8'd1;
                end
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

endmodule

// File: rtl/melody_player.sv
// -----------------------------------------------------------------------------
// melody_player
//   Plays a melody stored in an external ROM by writing note codes to a
//   speaker peripheral. Each ROM word is {note, duration}; a duration of 0
//   ends the song. Every note is followed by a silent gap of GAP_UNITS units.
//
// Peripheral bus protocol: there is no valid/ready handshake. A write is a
// single cycle with write_enable=1, address and data_out valid in that same
// cycle; the responder always accepts it. A read is address held with
// write_enable=0; the responder returns registered data on data_in one cycle
// later. write_enable is never high two cycles in a row and data_out is 0
// whenever write_enable is 0.
//
// Ports
//   clk          : clock, all state changes on posedge
//   reset        : asynchronous active-low reset
//   address      : peripheral bus address
//   data_out     : peripheral bus write data
//   data_in      : peripheral bus read data (registered by responder)
//   write_enable : one-cycle write strobe
//   start        : level, starts playback from index 0 while idle
//   stop         : level, aborts playback
//   auto_start   : poll the button register for a start request while idle
//   song_addr    : melody ROM index
//   song_data    : ROM word {note[15:8], duration[7:0]}, one-cycle latency
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse when playback ends or a stop completes
//   o_dbg_state  : current FSM state for observation
// -----------------------------------------------------------------------------
module melody_player
    import melody_player_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = 12000,
    parameter int unsigned GAP_UNITS      = 10,
    parameter int unsigned SPEAKER_ADDR   = DEF_SPEAKER_ADDR,
    parameter int unsigned BUTTON_ADDR    = DEF_BUTTON_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [5:0]  address,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in,
    output logic        write_enable,
    input  logic        start,
    input  logic        stop,
    input  logic        auto_start,
    output logic [7:0]  song_addr,
    input  logic [15:0] song_data,
    output logic        busy,
    output logic        done,
    output state_t      o_dbg_state
);

    localparam logic [5:0] SPK_ADDR = 6'(SPEAKER_ADDR);
    localparam logic [5:0] BTN_ADDR = 6'(BUTTON_ADDR);
    localparam logic [7:0] GAP_LEN  = 8'(GAP_UNITS);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_index;
    logic [7:0] r_note;
    logic [7:0] r_dur;
    logic       r_first;        // first cycle after entering a state
    logic       r_poll_sample;  // second POLL cycle: data_in is valid
    logic       r_we_q;         // write_enable of the previous cycle
    logic       w_state_change;
    logic       w_timer_run;
    logic       w_timer_expire;
    logic [7:0] w_timer_units;
    logic       w_unused_data_in;

    // Only the button bit of the read data matters.
    assign w_unused_data_in = ^data_in[7:1];

    assign w_state_change = (w_next != r_state);
    assign w_timer_run    = (r_state == ST_HOLD) || (r_state == ST_GAP);
    assign w_timer_units  = (w_next == ST_HOLD) ? r_dur  :
                            (w_next == ST_GAP)  ? GAP_LEN : 8'd0;

    // The timer is reloaded on every state change, so its counters are
    // cleared on every state entry and always start fresh in HOLD and GAP.
    melody_player_unit_timer #(
        .TICKS_PER_UNIT (TICKS_PER_UNIT)
    ) u_unit_timer (
        .i_clk     (clk),
        .i_reset_n (reset),
        .i_load    (w_state_change),
        .i_units   (w_timer_units),
        .i_run     (w_timer_run),
        .o_expire  (w_timer_expire)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_FETCH;
                end else if (auto_start) begin
                    w_next = ST_POLL;
                end
            end
            ST_POLL: begin
                if (r_poll_sample) begin
                    w_next = data_in[0] ? ST_FETCH : ST_IDLE;
                end
            end
            ST_FETCH:    w_next = ST_WAIT_ROM;
            ST_WAIT_ROM: w_next = (song_data[7:0] == 8'd0) ? ST_SILENCE : ST_PLAY;
            ST_PLAY:     w_next = ST_HOLD;
            ST_HOLD: begin
                if (w_timer_expire) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_timer_expire) begin
                    w_next = ST_FETCH;
                end
            end
            ST_SILENCE: begin
                // If the previous cycle was a write, the silencing write
                // waits one cycle so the strobe never repeats back to back.
                if (!r_we_q) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Stop overrides every other transition, including timer expiry.
        if (stop && (r_state != ST_IDLE) && (r_state != ST_SILENCE)) begin
            w_next = ST_SILENCE;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        write_enable = 1'b0;
        data_out     = 8'd0;
        done         = 1'b0;
        case (r_state)
            ST_PLAY: begin
                write_enable = 1'b1;
                data_out     = r_note;
            end
            ST_GAP: begin
                write_enable = r_first;
            end
            ST_SILENCE: begin
                write_enable = !r_we_q;
                done         = !r_we_q;
            end
            default: begin
                write_enable = 1'b0;
            end
        endcase
        address     = write_enable ? SPK_ADDR : BTN_ADDR;
        busy        = (r_state != ST_IDLE);
        o_dbg_state = r_state;
    end

    assign song_addr = r_index;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index       <= 8'd0;
            r_note        <= 8'd0;
            r_dur         <= 8'd0;
            r_first       <= 1'b0;
            r_poll_sample <= 1'b0;
            r_we_q        <= 1'b0;
        end else begin
            r_first       <= w_state_change;
            r_poll_sample <= (r_state == ST_POLL) && !r_poll_sample;
            r_we_q        <= write_enable;

            // Every playback starts at index 0; index 255 wraps naturally.
            if (r_state == ST_IDLE) begin
                r_index <= 8'd0;
            end else if ((r_state == ST_GAP) && (w_next == ST_FETCH)) begin
                r_index <= r_index + 8'd1;
            end

            if (r_state == ST_WAIT_ROM) begin
                r_note <= song_data[15:8];
                r_dur  <= song_data[7:0];
            end
        end
    end

endmodule

// File: tb/tb_melody_player.sv
module tb_melody_player;
    import melody_player_pkg::*;

    localparam int TPU = 4;
    localparam int GU  = 1;
    localparam logic [5:0] SPK = 6'd9;
    localparam logic [5:0] BTN = 6'd0;

    // ------------------------------------------------------ clock / reset
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]  address;
    logic [7:0]  data_out;
    logic [7:0]  data_in = 8'd0;
    logic        write_enable;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        auto_start = 1'b0;
    logic [7:0]  song_addr;
    logic [15:0] song_data = 16'd0;
    logic        busy;
    logic        done;
    state_t      dbg_state;

    melody_player #(
        .TICKS_PER_UNIT (TPU),
        .GAP_UNITS      (GU),
        .SPEAKER_ADDR   (9),
        .BUTTON_ADDR    (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .data_out     (data_out),
        .data_in      (data_in),
        .write_enable (write_enable),
        .start        (start),
        .stop         (stop),
        .auto_start   (auto_start),
        .song_addr    (song_addr),
        .song_data    (song_data),
        .busy         (busy),
        .done         (done),
        .o_dbg_state  (dbg_state)
    );

    // ------------------------------------------------ ROM / bus responders
    logic [15:0] rom [256];
    logic        button = 1'b0;

    always @(posedge clk) song_data <= rom[song_addr];
    always @(posedge clk) data_in <= (address == BTN && !write_enable) ? {7'd0, button} : 8'h00;

    // ------------------------------------------------------------ counters
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------------------------------------------------- scoreboard
    // Event word: {delta[7:0], done, write_enable, address[5:0], data[7:0]}
    // delta = cycles since the previous event; 0 means "not checked".
    logic [23:0] exp_q[$];

    function automatic logic [23:0] ev(input int delta, input logic d, input logic [7:0] dat);
        return {8'(delta), d, 1'b1, SPK, dat};
    endfunction

    int   cyc = 0;
    int   last_ev = 0;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        logic [23:0] e;
        logic [15:0] got;
        int dt;
        cyc = cyc + 1;
        if (reset) begin
            if (write_enable || done) begin
                got = {done, write_enable, address, data_out};
                dt = cyc - last_ev;
                last_ev = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event got=%h expected=none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("event", 32'(got), 32'(e[15:0]));
                    if (e[23:16] != 8'd0) check("event_delta", 32'(dt), 32'(e[23:16]));
                end
            end
            if (write_enable) check("we_back_to_back", 32'(prev_we), 32'd0);
            else check("data_out_idle_zero", 32'(data_out), 32'd0);
        end
        prev_we = write_enable;
    end

    // ------------------------------------------------------- driver tasks
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_state(input state_t s, input int budget, input string name);
        int n = 0;
        while (dbg_state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(dbg_state), 32'(s));
    endtask

    task automatic wait_addr(input logic [7:0] a, input int budget, input string name);
        int n = 0;
        while (song_addr != a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(song_addr), 32'(a));
    endtask

    task automatic drain(input string name);
        repeat (6) @(negedge clk);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_address"}, 32'(address), 32'(BTN));
        check({name, "_write_enable"}, 32'(write_enable), 32'd0);
        check({name, "_data_out"}, 32'(data_out), 32'd0);
        check({name, "_song_addr"}, 32'(song_addr), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // --------------------------------------------------------- stimulus
    initial begin
        int n_busy;
        int n_bad;
        logic [7:0] after_wrap;

        for (int i = 0; i < 256; i++) rom[i] = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);

        // Single note {69,3} then end of song.
        rom[0] = {8'd69, 8'd3};
        rom[1] = 16'd0;
        exp_q.push_back(ev(0, 1'b0, 8'd69));
        exp_q.push_back(ev(13, 1'b0, 8'd0));
        exp_q.push_back(ev(6, 1'b1, 8'd0));
        pulse_start();
        wait_done(100, "basic_done");
        drain("basic");

        // Rest note {0,2}: rest write, two-unit hold, normal gap.
        rom[0] = {8'd0, 8'd2};
        exp_q.push_back(ev(0, 1'b0, 8'd0));
        exp_q.push_back(ev(9, 1'b0, 8'd0));
        exp_q.push_back(ev(6, 1'b1, 8'd0));
        pulse_start();
        wait_done(100, "rest_done");
        drain("rest");

        // Stop in the third HOLD cycle.
        rom[0] = {8'd72, 8'd5};
        exp_q.push_back(ev(0, 1'b0, 8'd72));
        exp_q.push_back(ev(4, 1'b1, 8'd0));
        pulse_start();
        wait_state(ST_HOLD, 20, "stop_reach_hold");
        @(negedge clk);
        @(negedge clk);
        stop = 1'b1;
        wait_done(10, "stop_done");
        stop = 1'b0;
        drain("stop");

        // Start held high across done restarts playback.
        rom[0] = {8'd62, 8'd1};
        exp_q.push_back(ev(0, 1'b0, 8'd62));
        exp_q.push_back(ev(5, 1'b0, 8'd0));
        exp_q.push_back(ev(6, 1'b1, 8'd0));
        exp_q.push_back(ev(4, 1'b0, 8'd62));
        exp_q.push_back(ev(5, 1'b0, 8'd0));
        exp_q.push_back(ev(6, 1'b1, 8'd0));
        @(negedge clk);
        start = 1'b1;
        wait_done(100, "restart_done1");
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(100, "restart_done2");
        drain("restart");

        // Auto start polling: button low gives IDLE,POLL,POLL cycles only.
        rom[0] = {8'd60, 8'd1};
        n_busy = 0;
        n_bad = 0;
        auto_start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (busy && dbg_state != ST_POLL) n_bad++;
        end
        check("poll_busy_outside_poll", 32'(n_bad), 32'd0);
        check("poll_busy_cycles", 32'(n_busy), 32'd20);
        exp_q.push_back(ev(0, 1'b0, 8'd60));
        exp_q.push_back(ev(5, 1'b0, 8'd0));
        exp_q.push_back(ev(6, 1'b1, 8'd0));
        button = 1'b1;
        wait_done(100, "poll_done");
        auto_start = 1'b0;
        button = 1'b0;
        drain("poll");

        // Reset during the second note's gap.
        rom[0] = {8'd65, 8'd1};
        rom[1] = {8'd66, 8'd2};
        rom[2] = 16'd0;
        exp_q.push_back(ev(0, 1'b0, 8'd65));
        exp_q.push_back(ev(5, 1'b0, 8'd0));
        exp_q.push_back(ev(6, 1'b0, 8'd66));
        exp_q.push_back(ev(9, 1'b0, 8'd0));
        pulse_start();
        wait_addr(8'd1, 50, "rst_gap_index1");
        wait_state(ST_GAP, 50, "rst_gap_reach_gap");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values("rst_gap");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        drain("rst_gap");

        // Index wrap: all entries {60,1}; stop in the hold after the wrap.
        for (int i = 0; i < 256; i++) rom[i] = {8'd60, 8'd1};
        for (int n = 0; n <= 256; n++) begin
            exp_q.push_back(ev((n == 0) ? 0 : 6, 1'b0, 8'd60));
            if (n < 256) exp_q.push_back(ev(5, 1'b0, 8'd0));
        end
        exp_q.push_back(ev(2, 1'b1, 8'd0));
        pulse_start();
        wait_addr(8'd255, 3500, "wrap_reach_255");
        for (int i = 0; i < 20 && song_addr == 8'd255; i++) @(negedge clk);
        after_wrap = song_addr;
        check("wrap_next_addr", 32'(after_wrap), 32'd0);
        wait_state(ST_HOLD, 20, "wrap_reach_hold");
        stop = 1'b1;
        wait_done(10, "wrap_stop_done");
        stop = 1'b0;
        drain("wrap");

        // ------------------------------------------------------- report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog got=timeout expected=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
